// File: rtl/tqvp_crc_engine_v2.sv
// rtl/tqvp_crc_engine_v2.sv - TinyQV CRC peripheral: byte FIFO feeding a configurable CRC engine
// Build option: define CRC_BYTE_PARALLEL_EN for one byte per clock instead of one bit per clock.

module tqvp_crc_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [2:0]    push_n,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Caller guarantees push_n fits in the free space and pop only when non-empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(push_n)) mem[wr_ptr + AW'(k)] <= push_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(push_n);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (push ? CW'(push_n) : CW'(0)) - CW'(pop);
        end
    end

    assign pop_data = mem[rd_ptr];
endmodule

module tqvp_crc_step #(
    parameter int CRC_W = 32,
    parameter int NBITS = 8
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [CRC_W-1:0] poly,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);
    logic unused_data;
    assign unused_data = ^data;

    // Consumes the top NBITS bits of data, MSB first.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < NBITS; i++) begin
            if (crc_out[CRC_W-1] ^ data[7-i]) crc_out = {crc_out[CRC_W-2:0], 1'b0} ^ poly;
            else                              crc_out = {crc_out[CRC_W-2:0], 1'b0};
        end
    end
endmodule

module tqvp_crc_engine_v2 #(
    parameter int CRC_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] POLY_DEF = 32'h04C11DB7;
    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_CONFIG = 6'h04;
    localparam logic [5:0] A_DATA   = 6'h08;
    localparam logic [5:0] A_RESULT = 6'h0C;
    localparam logic [5:0] A_POLY   = 6'h10;
    localparam logic [5:0] A_INIT   = 6'h14;
    localparam logic [5:0] A_STATUS = 6'h18;
`ifdef CRC_BYTE_PARALLEL_EN
    localparam int STEP_BITS = 8;
`else
    localparam int STEP_BITS = 1;
`endif

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           state, state_nxt;
    logic             ctrl_en, irq_en;
    logic [2:0]       cfg;
    logic [CRC_W-1:0] poly, init, crc, crc_nxt, crc_rev, result;
    logic [7:0]       shreg;
    logic             done, overflow, busy, busy_q;
    logic             wr, rd, clear, data_wr, push, pop, last_bit;
    logic [2:0]       wr_n;
    logic [3:0]       wr_be;
    logic [CW-1:0]    fifo_count, fifo_free;
    logic [7:0]       fifo_data;
    logic             unused_ui;

    assign unused_ui = ^ui_in;
    assign uo_out    = 8'h00;

    assign wr = (data_write_n != 2'b11);
    assign rd = (data_read_n  != 2'b11);

    always_comb begin
        wr_n  = 3'd4;
        wr_be = 4'b1111;
        case (data_write_n)
            2'b00:   begin wr_n = 3'd1; wr_be = 4'b0001; end
            2'b01:   begin wr_n = 3'd2; wr_be = 4'b0011; end
            default: begin wr_n = 3'd4; wr_be = 4'b1111; end
        endcase
    end

    assign clear     = wr && (address == A_CTRL) && data_in[1];
    assign busy      = (state != S_IDLE) || (fifo_count != '0);
    assign fifo_free = CW'(FIFO_DEPTH) - fifo_count;
    assign data_wr   = wr && (address == A_DATA) && ctrl_en && !clear;
    assign push      = data_wr && (CW'(wr_n) <= fifo_free);

    tqvp_crc_byte_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (clear),
        .push      (push),
        .push_n    (wr_n),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count)
    );

    tqvp_crc_step #(.CRC_W(CRC_W), .NBITS(STEP_BITS)) u_step (
        .crc_in  (crc),
        .poly    (poly),
        .data    (shreg),
        .crc_out (crc_nxt)
    );

`ifdef CRC_BYTE_PARALLEL_EN
    assign last_bit = 1'b1;
`else
    logic [2:0] bit_cnt;
    assign last_bit = (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      bit_cnt <= '0;
        else if (clear || pop)           bit_cnt <= '0;
        else if (state == S_SHIFT)       bit_cnt <= bit_cnt + 3'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Chaining the next pop into the last shift cycle keeps the byte rate exact.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (fifo_count != '0) pop = 1'b1;
                    else                  state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (clear) begin
            pop       = 1'b0;
            state_nxt = S_IDLE;
        end
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc   <= '1;
            shreg <= '0;
        end else if (clear) begin
            crc <= init;
        end else begin
            if (state == S_SHIFT) begin
                crc   <= crc_nxt;
                shreg <= {shreg[6:0], 1'b0};
            end
            if (pop) shreg <= cfg[0] ? rev8(fifo_data) : fifo_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en  <= 1'b0;
            irq_en   <= 1'b0;
            cfg      <= 3'h7;
            poly     <= POLY_DEF[CRC_W-1:0];
            init     <= '1;
            done     <= 1'b0;
            overflow <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= busy && !clear;
            if (wr && address == A_CTRL) begin
                ctrl_en <= data_in[0];
                irq_en  <= data_in[2];
            end
            if (wr && !busy && address == A_CONFIG) cfg <= data_in[2:0];
            for (int i = 0; i < CRC_W; i++) begin
                if (wr && !busy && address == A_POLY && wr_be[i/8]) poly[i] <= data_in[i];
                if (wr && !busy && address == A_INIT && wr_be[i/8]) init[i] <= data_in[i];
            end
            if (wr && address == A_STATUS) begin
                if (data_in[1]) done     <= 1'b0;
                if (data_in[2]) overflow <= 1'b0;
            end
            if (busy_q && !busy)   done     <= 1'b1;
            if (data_wr && !push)  overflow <= 1'b1;
            if (clear) begin
                done     <= 1'b0;
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CRC_W; i++) crc_rev[i] = crc[CRC_W-1-i];
        result = (cfg[1] ? crc_rev : crc) ^ {CRC_W{cfg[2]}};
    end

    always_comb begin
        data_out = '0;
        case (address)
            A_CTRL:   data_out = {29'b0, irq_en, 1'b0, ctrl_en};
            A_CONFIG: data_out = {29'b0, cfg};
            A_RESULT: data_out = 32'(result);
            A_POLY:   data_out = 32'(poly);
            A_INIT:   data_out = 32'(init);
            A_STATUS: data_out = {16'b0, 8'(fifo_count), 5'b0, overflow, done, busy};
            default:  data_out = '0;
        endcase
    end

    assign data_ready     = !(rd && (address == A_RESULT) && busy);
    assign user_interrupt = done && irq_en;
endmodule

// File: tb/tb_tqvp_crc_engine_v2.sv
// tb/tb_tqvp_crc_engine_v2.sv - directed bench for tqvp_crc_engine_v2 (32-bit and 16-bit instances)

module tb_tqvp_crc_engine_v2;
    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_CONFIG = 6'h04;
    localparam logic [5:0] A_DATA   = 6'h08;
    localparam logic [5:0] A_RESULT = 6'h0C;
    localparam logic [5:0] A_POLY   = 6'h10;
    localparam logic [5:0] A_INIT   = 6'h14;
    localparam logic [5:0] A_STATUS = 6'h18;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [5:0]  a_addr, b_addr;
    logic [31:0] a_din, b_din, a_dout, b_dout;
    logic [1:0]  a_wn, a_rn, b_wn, b_rn;
    logic        a_rdy, b_rdy, a_irq, b_irq;
    logic [7:0]  a_uo, b_uo;
    int          errors;
    int          checks;

    tqvp_crc_engine_v2 #(.CRC_W(32), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(a_uo), .address(a_addr),
        .data_in(a_din), .data_write_n(a_wn), .data_read_n(a_rn), .data_out(a_dout),
        .data_ready(a_rdy), .user_interrupt(a_irq)
    );

    tqvp_crc_engine_v2 #(.CRC_W(16), .FIFO_DEPTH(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(b_uo), .address(b_addr),
        .data_in(b_din), .data_write_n(b_wn), .data_read_n(b_rn), .data_out(b_dout),
        .data_ready(b_rdy), .user_interrupt(b_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input bit sel, input logic [5:0] addr, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        if (!sel) begin a_addr = addr; a_din = d; a_wn = sz; end
        else      begin b_addr = addr; b_din = d; b_wn = sz; end
        @(negedge clk);
        a_wn = 2'b11;
        b_wn = 2'b11;
    endtask

    task automatic bus_read(input bit sel, input logic [5:0] addr, output logic [31:0] d, output int stalls);
        @(negedge clk);
        if (!sel) begin a_addr = addr; a_rn = 2'b10; end
        else      begin b_addr = addr; b_rn = 2'b10; end
        #1;
        stalls = 0;
        while (!(sel ? b_rdy : a_rdy) && stalls < 400) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!(sel ? b_rdy : a_rdy)) begin
            checks++;
            errors++;
            $display("FAIL read_timeout addr=%h got data_ready=0 exp data_ready=1", addr);
        end
        d = sel ? b_dout : a_dout;
        a_rn = 2'b11;
        b_rn = 2'b11;
    endtask

    task automatic push_check_string(input bit sel);
        bus_write(sel, A_DATA, 32'h34333231, SZ_W);
        bus_write(sel, A_DATA, 32'h38373635, SZ_W);
        bus_write(sel, A_DATA, 32'h00000039, SZ_B);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int st;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (a_uo !== 8'h00) begin errors++; $display("FAIL rst_uo_out got=%h exp=00", a_uo); end
        checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", a_irq); end
        bus_read(0, A_CTRL, d, st);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got=%h exp=00000000", d); end
        bus_read(0, A_CONFIG, d, st);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL rst_config got=%h exp=00000007", d); end
        bus_read(0, A_POLY, d, st);
        checks++; if (d !== 32'h04C11DB7) begin errors++; $display("FAIL rst_poly got=%h exp=04c11db7", d); end
        bus_read(0, A_INIT, d, st);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL rst_init got=%h exp=ffffffff", d); end
        bus_read(0, A_STATUS, d, st);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got=%h exp=00000000", d); end
        bus_read(0, A_RESULT, d, st);
        checks++; if (d !== 32'h0 || st != 0) begin errors++; $display("FAIL rst_result got=%h/%0d exp=00000000/0", d, st); end
        bus_read(0, A_DATA, d, st);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_data_read got=%h exp=00000000", d); end
        bus_read(0, 6'h1C, d, st);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_unmapped got=%h exp=00000000", d); end
        bus_read(1, A_POLY, d, st);
        checks++; if (d !== 32'h00001DB7) begin errors++; $display("FAIL rst_poly16 got=%h exp=00001db7", d); end
        bus_read(1, A_INIT, d, st);
        checks++; if (d !== 32'h0000FFFF) begin errors++; $display("FAIL rst_init16 got=%h exp=0000ffff", d); end
    endtask

    task automatic test_partial_writes();
        logic [31:0] d;
        int st;
        bus_write(0, A_POLY, 32'h000000AA, SZ_B);
        bus_read(0, A_POLY, d, st);
        checks++; if (d !== 32'h04C11DAA) begin errors++; $display("FAIL poly_byte_write got=%h exp=04c11daa", d); end
        bus_write(0, A_INIT, 32'h00001234, SZ_H);
        bus_read(0, A_INIT, d, st);
        checks++; if (d !== 32'hFFFF1234) begin errors++; $display("FAIL init_half_write got=%h exp=ffff1234", d); end
        bus_write(0, A_POLY, 32'h04C11DB7, SZ_W);
        bus_write(0, A_INIT, 32'hFFFFFFFF, SZ_W);
        bus_read(0, A_POLY, d, st);
        checks++; if (d !== 32'h04C11DB7) begin errors++; $display("FAIL poly_restore got=%h exp=04c11db7", d); end
    endtask

    task automatic test_crc32();
        logic [31:0] d;
        int st;
        bus_write(0, A_CTRL, 32'h1, SZ_W);
        push_check_string(0);
        bus_read(0, A_RESULT, d, st);
        checks++; if (st <= 0) begin errors++; $display("FAIL crc32_stall got=%0d exp=>0", st); end
        checks++; if (d !== 32'hCBF43926) begin errors++; $display("FAIL crc32_result got=%h exp=cbf43926", d); end
        bus_read(0, A_STATUS, d, st);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL crc32_status got=%h exp=00000002", d); end
        checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL crc32_irq_masked got=%b exp=0", a_irq); end
    endtask

    task automatic test_mpeg2_irq();
        logic [31:0] d;
        int st;
        bus_write(0, A_CONFIG, 32'h0, SZ_W);
        bus_write(0, A_CTRL, 32'h3, SZ_W);
        push_check_string(0);
        bus_read(0, A_RESULT, d, st);
        checks++; if (d !== 32'h0376E6E7) begin errors++; $display("FAIL mpeg2_result got=%h exp=0376e6e7", d); end
        @(negedge clk);
        checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL mpeg2_irq_off got=%b exp=0", a_irq); end
        bus_write(0, A_CTRL, 32'h5, SZ_W);
        checks++; if (a_irq !== 1'b1) begin errors++; $display("FAIL mpeg2_irq_on got=%b exp=1", a_irq); end
        bus_write(0, A_STATUS, 32'h2, SZ_W);
        checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL done_clear_irq got=%b exp=0", a_irq); end
        bus_read(0, A_STATUS, d, st);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL done_clear_status got=%h exp=00000000", d); end
    endtask

    task automatic test_crc16();
        logic [31:0] d;
        int st;
        bus_write(1, A_POLY, 32'h00001021, SZ_W);
        bus_write(1, A_INIT, 32'h0000FFFF, SZ_W);
        bus_write(1, A_CONFIG, 32'h0, SZ_W);
        bus_write(1, A_CTRL, 32'h3, SZ_W);
        bus_read(1, A_POLY, d, st);
        checks++; if (d !== 32'h00001021) begin errors++; $display("FAIL crc16_poly got=%h exp=00001021", d); end
        push_check_string(1);
        bus_read(1, A_RESULT, d, st);
        checks++; if (d !== 32'h000029B1) begin errors++; $display("FAIL crc16_result got=%h exp=000029b1", d); end
    endtask

    task automatic test_overflow_clear();
        logic [31:0] d;
        int st;
        bus_write(0, A_CTRL, 32'h3, SZ_W);
        bus_write(0, A_DATA, 32'h44332211, SZ_W);
        bus_write(0, A_DATA, 32'h88776655, SZ_W);
        bus_write(0, A_DATA, 32'hCCBBAA99, SZ_W);
        bus_read(0, A_STATUS, d, st);
        checks++; if (d !== 32'h00000705) begin errors++; $display("FAIL overflow_status got=%h exp=00000705", d); end
        bus_write(0, A_DATA, 32'h000000DD, SZ_B);
        bus_read(0, A_STATUS, d, st);
        checks++; if (d !== 32'h00000805) begin errors++; $display("FAIL fifo_full_status got=%h exp=00000805", d); end
        bus_write(0, A_CTRL, 32'h3, SZ_W);
        bus_read(0, A_STATUS, d, st);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_status got=%h exp=00000000", d); end
        bus_read(0, A_RESULT, d, st);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL clear_result_raw got=%h exp=ffffffff", d); end
        bus_write(0, A_CONFIG, 32'h7, SZ_W);
        bus_read(0, A_RESULT, d, st);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_result_refl got=%h exp=00000000", d); end
        push_check_string(0);
        bus_read(0, A_RESULT, d, st);
        checks++; if (d !== 32'hCBF43926) begin errors++; $display("FAIL after_clear_result got=%h exp=cbf43926", d); end
    endtask

    task automatic test_reset_mid_shift();
        bus_write(0, A_CONFIG, 32'h0, SZ_W);
        bus_write(0, A_POLY, 32'h12345678, SZ_W);
        bus_write(0, A_INIT, 32'h0, SZ_W);
        bus_write(0, A_CTRL, 32'h5, SZ_W);
        bus_write(0, A_DATA, 32'h34333231, SZ_W);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL async_rst_irq got=%b exp=0", a_irq); end
        a_rn = 2'b10;
        a_addr = A_STATUS; #1;
        checks++; if (a_dout !== 32'h0) begin errors++; $display("FAIL async_rst_status got=%h exp=00000000", a_dout); end
        a_addr = A_CONFIG; #1;
        checks++; if (a_dout !== 32'h7) begin errors++; $display("FAIL async_rst_config got=%h exp=00000007", a_dout); end
        a_addr = A_POLY; #1;
        checks++; if (a_dout !== 32'h04C11DB7) begin errors++; $display("FAIL async_rst_poly got=%h exp=04c11db7", a_dout); end
        a_addr = A_INIT; #1;
        checks++; if (a_dout !== 32'hFFFFFFFF) begin errors++; $display("FAIL async_rst_init got=%h exp=ffffffff", a_dout); end
        a_addr = A_CTRL; #1;
        checks++; if (a_dout !== 32'h0) begin errors++; $display("FAIL async_rst_ctrl got=%h exp=00000000", a_dout); end
        a_addr = A_RESULT; #1;
        checks++; if (a_dout !== 32'h0) begin errors++; $display("FAIL async_rst_result got=%h exp=00000000", a_dout); end
        a_rn = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_busy_write_ignore();
        logic [31:0] d;
        int st;
        bus_write(0, A_CTRL, 32'h1, SZ_W);
        bus_write(0, A_DATA, 32'h34333231, SZ_W);
        bus_write(0, A_POLY, 32'hDEADBEEF, SZ_W);
        bus_read(0, A_STATUS, d, st);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL busy_flag got=%b exp=1", d[0]); end
        bus_read(0, A_POLY, d, st);
        checks++; if (d !== 32'h04C11DB7) begin errors++; $display("FAIL busy_poly_write got=%h exp=04c11db7", d); end
        bus_write(0, A_CONFIG, 32'h0, SZ_W);
        bus_read(0, A_CONFIG, d, st);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL busy_config_write got=%h exp=00000007", d); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        a_addr = 6'h0; a_din = 32'h0; a_wn = 2'b11; a_rn = 2'b11;
        b_addr = 6'h0; b_din = 32'h0; b_wn = 2'b11; b_rn = 2'b11;
        test_reset();
        test_partial_writes();
        test_crc32();
        test_mpeg2_irq();
        test_crc16();
        test_overflow_clear();
        test_reset_mid_shift();
        test_busy_write_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
